// File: rtl/wb_periph_interconnect.sv
// wb_periph_interconnect
// Wishbone classic 1-master -> N_PERIPH-slave interconnect. The slot is
// decoded from addr_i[SEL_LSB +: SEL_W]. The request is registered and driven
// to the selected slave. The slave's ack/data come back as a one-cycle
// ack_o/data_o. Unmapped slots and slaves that never ack are answered with a
// one-cycle err_o.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   cyc_i/stb_i/we_i            master request qualifiers
//   sel_i/addr_i/data_i         master byte enables, address, write data
//   data_o/ack_o/err_o          response to master (1-cycle pulses)
//   p_cyc_o/p_stb_o             per-slot cycle/strobe, one-hot or zero
//   p_we_o/p_sel_o/p_addr_o/p_data_o  registered request, shared by all slots
//   p_ack_i/p_data_i            per-slot ack and read data (slot k at [32k+:32])
//
// States
//   IDLE | waiting for cyc_i & stb_i
//   BUSY | strobing the selected slave, counting towards TIMEOUT
//   RESP | ack_o with captured read word
//   ERR  | err_o for unmapped slot or timeout
module wb_periph_interconnect #(
  parameter int N_PERIPH = 8,
  parameter int SEL_W    = 3,
  parameter int SEL_LSB  = 28,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cyc_i,
  input  logic                  stb_i,
  input  logic                  we_i,
  input  logic [3:0]            sel_i,
  input  logic [31:0]           addr_i,
  input  logic [31:0]           data_i,
  output logic [31:0]           data_o,
  output logic                  ack_o,
  output logic                  err_o,
  output logic [N_PERIPH-1:0]   p_cyc_o,
  output logic [N_PERIPH-1:0]   p_stb_o,
  output logic                  p_we_o,
  output logic [3:0]            p_sel_o,
  output logic [31:0]           p_addr_o,
  output logic [31:0]           p_data_o,
  input  logic [N_PERIPH-1:0]   p_ack_i,
  input  logic [32*N_PERIPH-1:0] p_data_i
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_e;

  state_e               state_q;
  logic [SEL_W-1:0]     slot_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [N_PERIPH-1:0]  stb_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q;
  logic                 ack_q;
  logic                 err_q;

  logic [SEL_W-1:0]     slot_d;
  logic                 slot_mapped;
  logic [N_PERIPH-1:0]  stb_d;
  logic                 ack_sel;
  logic [31:0]          rdata_sel;
  logic                 timeout_hit;

  assign slot_d = addr_i[SEL_LSB +: SEL_W];
  // Compare at 32 bits: N_PERIPH may equal 2**SEL_W, which does not fit SEL_W.
  assign slot_mapped = ({{(32-SEL_W){1'b0}}, slot_d} < 32'(N_PERIPH));
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  // stb_d decodes the incoming address; ack/data mux follows the latched slot,
  // so acks from non-selected slots never reach the FSM.
  always_comb begin
    stb_d     = '0;
    ack_sel   = 1'b0;
    rdata_sel = '0;
    for (int k = 0; k < N_PERIPH; k++) begin
      stb_d[k] = (slot_d == SEL_W'(k));
      if (slot_q == SEL_W'(k)) begin
        ack_sel   = p_ack_i[k];
        rdata_sel = p_data_i[32*k +: 32];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      slot_q  <= '0;
      cnt_q   <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // Response outputs are pulses; data_o reads zero except during RESP.
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (cyc_i && stb_i) begin
            we_q    <= we_i;
            sel_q   <= sel_i;
            addr_q  <= addr_i;
            wdata_q <= data_i;
            slot_q  <= slot_d;
            cnt_q   <= '0;
            if (slot_mapped) begin
              state_q <= BUSY;
              stb_q   <= stb_d;
            end else begin
              state_q <= ERR;
              err_q   <= 1'b1;
            end
          end
        end
        BUSY: begin
          // Priority: master abort, then slave ack, then timeout.
          if (!cyc_i) begin
            state_q <= IDLE;
            stb_q   <= '0;
          end else if (ack_sel) begin
            state_q <= RESP;
            stb_q   <= '0;
            ack_q   <= 1'b1;
            rdata_q <= rdata_sel;
          end else if (timeout_hit) begin
            state_q <= ERR;
            stb_q   <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o   = rdata_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;
  assign p_cyc_o  = stb_q;
  assign p_stb_o  = stb_q;
  assign p_we_o   = we_q;
  assign p_sel_o  = sel_q;
  assign p_addr_o = addr_q;
  assign p_data_o = wdata_q;

endmodule

// File: tb/tb_wb_periph_interconnect.sv
module tb_wb_periph_interconnect;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 8-slot instance
  logic        cyc = 0, stb = 0, we = 0;
  logic [3:0]  sel = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [31:0] data_o;
  logic        ack_o, err_o;
  logic [7:0]  p_cyc_o, p_stb_o;
  logic [7:0]  p_ack = 0;
  logic        p_we_o;
  logic [3:0]  p_sel_o;
  logic [31:0] p_addr_o, p_data_o;
  logic [255:0] p_rdata = 0;

  // 5-slot instance
  logic        b_cyc = 0, b_stb = 0;
  logic [31:0] b_addr = 0;
  logic [31:0] b_data_o;
  logic        b_ack_o, b_err_o;
  logic [4:0]  b_cyc_o, b_stb_o;
  logic [4:0]  b_ack = 0;
  logic        b_we_o;
  logic [3:0]  b_sel_o;
  logic [31:0] b_paddr_o, b_pdata_o;
  logic [159:0] b_rdata = 0;

  wb_periph_interconnect #(.N_PERIPH(8), .SEL_W(3), .SEL_LSB(28), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .cyc_i(cyc), .stb_i(stb), .we_i(we), .sel_i(sel),
    .addr_i(addr), .data_i(wdata), .data_o(data_o), .ack_o(ack_o), .err_o(err_o),
    .p_cyc_o(p_cyc_o), .p_stb_o(p_stb_o), .p_we_o(p_we_o), .p_sel_o(p_sel_o),
    .p_addr_o(p_addr_o), .p_data_o(p_data_o), .p_ack_i(p_ack), .p_data_i(p_rdata)
  );

  wb_periph_interconnect #(.N_PERIPH(5), .SEL_W(3), .SEL_LSB(28), .TIMEOUT(TO)) dut5 (
    .clk(clk), .rst_n(rst_n), .cyc_i(b_cyc), .stb_i(b_stb), .we_i(1'b0), .sel_i(4'hF),
    .addr_i(b_addr), .data_i(32'h0), .data_o(b_data_o), .ack_o(b_ack_o), .err_o(b_err_o),
    .p_cyc_o(b_cyc_o), .p_stb_o(b_stb_o), .p_we_o(b_we_o), .p_sel_o(b_sel_o),
    .p_addr_o(b_paddr_o), .p_data_o(b_pdata_o), .p_ack_i(b_ack), .p_data_i(b_rdata)
  );

  typedef struct {
    logic [2:0]  slot;
    logic        wr;
    logic [27:0] off;
    logic [31:0] wd;
    logic [3:0]  be;
    int          lat;     // BUSY cycles the slave waits before acking
    logic [31:0] sd;      // slave read word
    logic        exp_err;
    int          exp_n;   // cycles from request sample to ack_o/err_o
    logic [31:0] exp_d;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Transaction-level reference: outcome and latency of one request.
  function automatic void model(input int slot, input int lat, input int np, input int to,
                                output bit e, output int n);
    if (slot >= np) begin
      e = 1'b1; n = 1;
    end else if (lat + 1 <= to) begin
      e = 1'b0; n = lat + 2;
    end else begin
      e = 1'b1; n = to + 1;
    end
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, " data_o"}, data_o, 32'h0);
    chk({tag, " ack_o"}, {31'h0, ack_o}, 32'h0);
    chk({tag, " err_o"}, {31'h0, err_o}, 32'h0);
    chk({tag, " p_stb_o"}, {24'h0, p_stb_o}, 32'h0);
    chk({tag, " p_cyc_o"}, {24'h0, p_cyc_o}, 32'h0);
    chk({tag, " p_we_o"}, {31'h0, p_we_o}, 32'h0);
    chk({tag, " p_sel_o"}, {28'h0, p_sel_o}, 32'h0);
    chk({tag, " p_addr_o"}, p_addr_o, 32'h0);
    chk({tag, " p_data_o"}, p_data_o, 32'h0);
  endtask

  task automatic run_txn(input vec_t v, input string tag);
    int n, busy, bad;
    bit done;
    logic [7:0] onehot;
    onehot = 8'd1 << v.slot;
    @(negedge clk);
    for (int k = 0; k < 8; k++) p_rdata[32*k +: 32] = $urandom;
    p_rdata[32*v.slot +: 32] = v.sd;
    cyc = 1; stb = 1; we = v.wr; sel = v.be; wdata = v.wd;
    addr = {1'b0, v.slot, v.off};
    p_ack = '0;
    n = 0; busy = 0; bad = 0; done = 0;
    while (!done && n < 60) begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 1) begin
        chk({tag, " p_addr_o"}, p_addr_o, {1'b0, v.slot, v.off});
        chk({tag, " p_we_o"}, {31'h0, p_we_o}, {31'h0, v.wr});
        chk({tag, " p_sel_o"}, {28'h0, p_sel_o}, {28'h0, v.be});
        chk({tag, " p_data_o"}, p_data_o, v.wd);
      end
      if (p_stb_o !== 8'h0 && (p_stb_o !== onehot || p_cyc_o !== p_stb_o)) bad++;
      if (ack_o && err_o) bad++;
      if (ack_o || err_o) done = 1;
      else begin
        if (p_stb_o[v.slot]) busy++;
        // spurious acks on every other slot
        p_ack = 8'($urandom) & ~onehot;
        if (p_stb_o[v.slot] && busy >= v.lat + 1) p_ack[v.slot] = 1'b1;
      end
    end
    chk({tag, " completed"}, {31'h0, done}, 32'h1);
    chk({tag, " err_o"}, {31'h0, err_o}, {31'h0, v.exp_err});
    chk({tag, " ack_o"}, {31'h0, ack_o}, {31'h0, ~v.exp_err});
    chk({tag, " latency"}, n, v.exp_n);
    chk({tag, " data_o"}, data_o, v.exp_d);
    chk({tag, " stb cleared"}, {24'h0, p_stb_o}, 32'h0);
    chk({tag, " strobe/ack protocol"}, bad, 0);
    cyc = 0; stb = 0; p_ack = '0;
  endtask

  task automatic run_b(input int slot);
    int n, seen, en;
    bit done, e;
    @(negedge clk);
    for (int k = 0; k < 5; k++) b_rdata[32*k +: 32] = 32'hB000_0000 + k;
    b_cyc = 1; b_stb = 1; b_addr = 32'(slot) << 28; b_ack = '0;
    n = 0; seen = 0; done = 0;
    while (!done && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
      if (b_stb_o !== 5'h0) seen++;
      if (b_ack_o || b_err_o) done = 1;
      else b_ack = b_stb_o;
    end
    model(slot, 0, 5, TO, e, en);
    chk($sformatf("n5 slot%0d completed", slot), {31'h0, done}, 32'h1);
    chk($sformatf("n5 slot%0d err_o", slot), {31'h0, b_err_o}, {31'h0, e});
    chk($sformatf("n5 slot%0d latency", slot), n, en);
    chk($sformatf("n5 slot%0d data_o", slot), b_data_o, e ? 32'h0 : 32'hB000_0000 + slot);
    chk($sformatf("n5 slot%0d strobe cycles", slot), seen, e ? 0 : 1);
    b_cyc = 0; b_stb = 0; b_ack = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    bit e;
    int en;

    //            slot  wr    off        wd            be    lat  sd            err   n   data
    vecs[0] = '{3'd2, 1'b0, 28'h10,   32'h0,        4'hF, 3,  32'hDEAD_BEEF, 1'b0, 5,  32'hDEAD_BEEF};
    vecs[1] = '{3'd7, 1'b1, 28'h4,    32'h1234_5678, 4'hF, 0,  32'hA5A5_0007, 1'b0, 2,  32'hA5A5_0007};
    vecs[2] = '{3'd0, 1'b0, 28'h0,    32'h0,        4'hF, 20, 32'h1111_0000, 1'b1, 17, 32'h0};
    vecs[3] = '{3'd1, 1'b0, 28'h8,    32'h0,        4'h3, 15, 32'h2222_0001, 1'b0, 17, 32'h2222_0001};
    vecs[4] = '{3'd1, 1'b1, 28'hC,    32'hCAFE_0001, 4'h1, 16, 32'h3333_0001, 1'b1, 17, 32'h0};
    vecs[5] = '{3'd5, 1'b0, 28'h100,  32'h0,        4'hF, 1,  32'h0505_5A5A, 1'b0, 3,  32'h0505_5A5A};

    @(negedge clk); @(negedge clk);
    check_zero("reset");
    chk("reset n5 stb", {27'h0, b_stb_o}, 32'h0);
    rst_n = 1;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // master abort two cycles into BUSY, with a slave ack in the same cycle
    @(negedge clk);
    p_ack = '0; cyc = 1; stb = 1; we = 0; addr = 32'h3000_0000;
    @(posedge clk); @(negedge clk);
    chk("abort busy stb", {24'h0, p_stb_o}, 32'h08);
    @(posedge clk); @(negedge clk);
    chk("abort busy2 ack_o", {31'h0, ack_o}, 32'h0);
    cyc = 0; stb = 0; p_ack = 8'h08;
    @(posedge clk); @(negedge clk);
    chk("abort stb dropped", {24'h0, p_stb_o}, 32'h0);
    chk("abort ack_o", {31'h0, ack_o}, 32'h0);
    chk("abort err_o", {31'h0, err_o}, 32'h0);
    p_ack = '0;
    @(posedge clk); @(negedge clk);
    chk("abort after ack_o", {31'h0, ack_o}, 32'h0);
    chk("abort after err_o", {31'h0, err_o}, 32'h0);

    // async reset in the middle of BUSY
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; sel = 4'hA; addr = 32'h4000_0020; wdata = 32'h5555_AAAA;
    @(posedge clk); @(negedge clk);
    chk("pre-reset p_addr_o", p_addr_o, 32'h4000_0020);
    chk("pre-reset p_stb_o", {24'h0, p_stb_o}, 32'h10);
    #1 rst_n = 0;
    #1 check_zero("mid-busy reset");
    cyc = 0; stb = 0;
    @(negedge clk);
    rst_n = 1;

    // randomized transactions against the transaction model
    for (int i = 0; i < 40; i++) begin
      v.slot = 3'($urandom_range(0, 7));
      v.wr   = 1'($urandom);
      v.off  = 28'($urandom);
      v.wd   = $urandom;
      v.be   = 4'($urandom);
      v.lat  = $urandom_range(0, 18);
      v.sd   = $urandom;
      model(int'(v.slot), v.lat, 8, TO, e, en);
      v.exp_err = e;
      v.exp_n   = en;
      v.exp_d   = e ? 32'h0 : v.sd;
      run_txn(v, $sformatf("rand%0d", i));
    end

    // 5-slot build: slots 5..7 unmapped
    for (int s = 0; s < 8; s++) run_b(s);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
